// File: rtl/conv_mac_engine.sv
// Convolution MAC engine: one KSIZE x KSIZE window per beat, one tap per cycle,
// channels accumulate across beats until the last one, then bias/shift/ReLU/saturate.
module conv_mac_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int KSIZE      = 3
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]     window_i,
  input  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]     weight_i,
  input  logic                                  last_i,
  input  logic signed [ACC_WIDTH-1:0]           bias_i,
  input  logic [4:0]                            cfg_shift_i,
  input  logic                                  cfg_relu_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic signed [OUT_WIDTH-1:0]           out_data_o,
  output logic                                  busy_o
);

  localparam int TAPS   = KSIZE * KSIZE;
  localparam int IDX_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    (ACC_WIDTH'(1) <<< (OUT_WIDTH - 1)) - ACC_WIDTH'(1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t state_q, state_d;

  logic [TAPS*DATA_WIDTH-1:0]      win_p0, wgt_p0;
  logic                            last_p0;
  logic signed [ACC_WIDTH-1:0]     bias_p0;
  logic [4:0]                      shift_p0;
  logic                            relu_p0;
  logic [IDX_W-1:0]                idx_p0;
  logic signed [ACC_WIDTH-1:0]     acc_p0;
  logic signed [OUT_WIDTH-1:0]     out_p1;

  logic signed [DATA_WIDTH-1:0]    win_tap [TAPS];
  logic signed [DATA_WIDTH-1:0]    wgt_tap [TAPS];
  logic signed [PROD_W-1:0]        prod;
  logic signed [ACC_WIDTH-1:0]     acc_next;
  logic                            accept, final_tap, out_fire;

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] v);
    if (v > OUT_MAX) return OUT_MAX[OUT_WIDTH-1:0];
    if (v < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    return v[OUT_WIDTH-1:0];
  endfunction

  // Floor shift happens before ReLU so that small negatives still clamp to zero.
  function automatic logic signed [ACC_WIDTH-1:0] shift_relu(input logic signed [ACC_WIDTH-1:0] v,
                                                             input logic [4:0] sh,
                                                             input logic relu);
    logic signed [ACC_WIDTH-1:0] s;
    s = v >>> sh;
    if (relu && (s < 0)) s = '0;
    return s;
  endfunction

  for (genvar t = 0; t < TAPS; t++) begin : g_tap
    assign win_tap[t] = win_p0[t*DATA_WIDTH +: DATA_WIDTH];
    assign wgt_tap[t] = wgt_p0[t*DATA_WIDTH +: DATA_WIDTH];
  end

  assign in_ready_o  = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = (state_q == OUT);
  assign out_data_o  = out_p1;

  assign accept    = in_valid_i && in_ready_o;
  assign final_tap = (state_q == MAC) && (idx_p0 == IDX_W'(TAPS - 1));
  assign out_fire  = out_valid_o && out_ready_i;

  assign prod     = win_tap[idx_p0] * wgt_tap[idx_p0];
  assign acc_next = acc_p0 + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid_i) state_d = MAC;
      MAC:     if (final_tap)  state_d = last_p0 ? OUT : IDLE;
      OUT:     if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: beat capture (pure data, no reset)
  always_ff @(posedge clk_i) begin
    if (accept) begin
      win_p0   <= window_i;
      wgt_p0   <= weight_i;
      last_p0  <= last_i;
      bias_p0  <= bias_i;
      shift_p0 <= cfg_shift_i;
      relu_p0  <= cfg_relu_i;
    end
  end

  // Stage p0->p1: tap accumulation and output formatting on the final tap
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_p0 <= '0;
      idx_p0 <= '0;
      out_p1 <= '0;
    end else if (accept) begin
      idx_p0 <= '0;
    end else if (state_q == MAC) begin
      acc_p0 <= acc_next;
      idx_p0 <= final_tap ? '0 : idx_p0 + IDX_W'(1);
      if (final_tap && last_p0)
        out_p1 <= sat_out(shift_relu(acc_next + bias_p0, shift_p0, relu_p0));
    end else if (out_fire) begin
      acc_p0 <= '0;
    end
  end

endmodule

// File: tb/tb_conv_mac_engine.sv
// Bench for conv_mac_engine: directed scenarios plus randomized multi-channel
// transactions against an integer-arithmetic reference model.
module tb_conv_mac_engine;

  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int OW   = 8;
  localparam int K    = 3;
  localparam int TAPS = K * K;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [TAPS*DW-1:0]     window_i;
  logic [TAPS*DW-1:0]     weight_i;
  logic                   last_i;
  logic signed [AW-1:0]   bias_i;
  logic [4:0]             cfg_shift_i;
  logic                   cfg_relu_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic signed [OW-1:0]   out_data_o;
  logic                   busy_o;

  always #5 clk_i = ~clk_i;

  conv_mac_engine #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .KSIZE(K)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .window_i(window_i), .weight_i(weight_i), .last_i(last_i), .bias_i(bias_i),
    .cfg_shift_i(cfg_shift_i), .cfg_relu_i(cfg_relu_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_bad = 0;
  int bw[TAPS];
  int bk[TAPS];
  int model_acc = 0;
  int exp_q = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_uniform(input int w, input int k);
    for (int i = 0; i < TAPS; i++) begin
      bw[i] = w;
      bk[i] = k;
    end
  endtask

  task automatic set_random();
    for (int i = 0; i < TAPS; i++) begin
      bw[i] = int'($urandom_range(0, 255)) - 128;
      bk[i] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  // Reference: dot product summed over channels, then bias/floor-shift/ReLU/clamp.
  task automatic send_beat(input bit last, input int bias, input int sh, input bit relu);
    int waitc;
    int r;
    waitc = 0;
    @(negedge clk_i);
    while (!in_ready_o && waitc < 100) begin
      @(negedge clk_i);
      waitc++;
    end
    if (!in_ready_o) chk("in_ready_timeout", 0, 1);
    for (int i = 0; i < TAPS; i++) begin
      window_i[i*DW +: DW] = bw[i][DW-1:0];
      weight_i[i*DW +: DW] = bk[i][DW-1:0];
    end
    last_i      = last;
    bias_i      = bias;
    cfg_shift_i = sh[4:0];
    cfg_relu_i  = relu;
    in_valid_i  = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    for (int i = 0; i < TAPS; i++) model_acc += bw[i] * bk[i];
    if (last) begin
      r = model_acc + bias;
      r = r >>> sh;
      if (relu && r < 0) r = 0;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      exp_q = r;
      model_acc = 0;
    end
  endtask

  task automatic finish_txn(input string tag, input int stall, input bit noise);
    int cyc;
    cyc = 1;
    while (cyc < 50) begin
      @(negedge clk_i);
      if (out_valid_o) break;
      if (noise) begin
        in_valid_i  = 1'($urandom_range(0, 1));
        for (int i = 0; i < TAPS; i++) window_i[i*DW +: DW] = 8'($urandom);
        last_i      = 1'b1;
        out_ready_i = 1'($urandom_range(0, 1));
      end
      @(posedge clk_i);
      #1 cyc++;
    end
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    chk({tag, "_lat"}, cyc, TAPS + 1);
    chk({tag, "_data"}, int'(out_data_o), exp_q);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk_i);
      chk({tag, "_hold_valid"}, int'(out_valid_o), 1);
      chk({tag, "_hold_data"}, int'(out_data_o), exp_q);
      chk({tag, "_hold_rdy"}, int'(in_ready_o), 0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
    chk({tag, "_rdy_after"}, int'(in_ready_o), 1);
    chk({tag, "_vld_after"}, int'(out_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nch, bias, sh;
    bit relu;
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; last_i = 1'b0;
    window_i = '0; weight_i = '0; bias_i = '0; cfg_shift_i = '0; cfg_relu_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", int'(out_valid_o), 0);
    chk("rst_data", int'(out_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    @(negedge clk_i) rst_ni = 1'b1;
    #1 chk("rst_ready", int'(in_ready_o), 1);

    set_uniform(1, 1);   send_beat(1, 0, 0, 0);  finish_txn("ones", 0, 0);
    set_uniform(2, 3);   send_beat(0, 555, 7, 1);
    set_uniform(-1, 4);  send_beat(1, 10, 0, 0); finish_txn("two_beat", 0, 0);
    set_uniform(127, 127);  send_beat(1, 0, 0, 0); finish_txn("sat_hi", 0, 0);
    set_uniform(-128, 127); send_beat(1, 0, 0, 0); finish_txn("sat_lo", 0, 0);
    set_uniform(-128, 127); send_beat(1, 0, 0, 1); finish_txn("relu", 0, 0);
    set_uniform(10, 10);    send_beat(1, 0, 4, 0); finish_txn("shift_pos", 0, 0);
    set_uniform(-10, 10);   send_beat(1, 0, 4, 0); finish_txn("shift_neg", 0, 0);
    set_uniform(1, 1);      send_beat(1, 0, 0, 0); finish_txn("backpressure", 5, 0);

    set_uniform(100, 100);  send_beat(0, 0, 0, 0);
    send_beat(1, 0, 0, 0);
    repeat (4) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_valid", int'(out_valid_o), 0);
    chk("midrst_data", int'(out_data_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_ready", int'(in_ready_o), 1);
    model_acc = 0;
    @(negedge clk_i) rst_ni = 1'b1;
    set_uniform(1, 1); send_beat(1, 0, 0, 0); finish_txn("after_rst", 0, 0);

    for (int t = 0; t < 25; t++) begin
      nch = int'($urandom_range(1, 3));
      for (int c = 0; c < nch; c++) begin
        set_random();
        bias = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 4000)) - 2000;
        sh   = int'($urandom_range(0, 12));
        relu = 1'($urandom_range(0, 1));
        send_beat(c == nch - 1, bias, sh, relu);
      end
      finish_txn("rnd", int'($urandom_range(0, 3)), 1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
